// File: rtl/gpio_bank.sv
// ============================================================================
// Module      : gpio_bank
// Description : CSR-mapped GPIO bank with synchronised, optionally debounced
//               inputs and per-pin edge/level interrupt capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_bank #(
    parameter logic [4:0] BASE_ADDR = 5'h00,
    parameter int         NUM_GPIOS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           csr_a,
    input  logic [7:0]           csr_di,
    input  logic                 csr_we,
    output logic [7:0]           csr_do,
    input  logic [NUM_GPIOS-1:0] in,
    output logic [NUM_GPIOS-1:0] out,
    output logic [NUM_GPIOS-1:0] oe,
    output logic                 irq
);

    localparam logic [15:0] c_PIN_MASK = 16'((32'd1 << NUM_GPIOS) - 32'd1);

    logic [15:0]      oe_q, oe_d, out_q, out_d, ie_q, ie_d, ip_q, ip_d;
    logic [15:0]      dbe_q, dbe_d, filt_q, filt_d, prev_q, sync1_q, sync2_q;
    logic [31:0]      mode_q, mode_d;
    logic [7:0]       dbp_q, dbp_d, presc_q, presc_d, csr_do_q;
    logic [15:0][1:0] dbcnt_q, dbcnt_d;
    logic             irq_q;

    logic [4:0]  w_off;
    logic [15:0] w_in, w_event, w_clr;
    logic        w_tick;
    logic [7:0]  w_rdata;

    assign w_off  = csr_a - BASE_ADDR;
    assign w_in   = 16'(in);
    assign w_tick = (presc_q == 8'd0);

    // Events look only at filt/prev, so a MODE rewrite cannot fabricate an edge.
    always_comb begin
        w_event = '0;
        for (int n = 0; n < 16; n++) begin
            case (mode_q[2*n +: 2])
                2'b00:   w_event[n] = filt_q[n] ^ prev_q[n];
                2'b01:   w_event[n] = filt_q[n] & ~prev_q[n];
                2'b10:   w_event[n] = ~filt_q[n] & prev_q[n];
                default: w_event[n] = ~filt_q[n];
            endcase
        end
    end

    always_comb begin
        oe_d    = oe_q;
        out_d   = out_q;
        ie_d    = ie_q;
        mode_d  = mode_q;
        dbe_d   = dbe_q;
        dbp_d   = dbp_q;
        w_clr   = '0;
        if (csr_we) begin
            case (w_off)
                5'h00:   oe_d[7:0]     = csr_di;
                5'h01:   oe_d[15:8]    = csr_di;
                5'h02:   out_d[7:0]    = csr_di;
                5'h03:   out_d[15:8]   = csr_di;
                5'h06:   ie_d[7:0]     = csr_di;
                5'h07:   ie_d[15:8]    = csr_di;
                5'h08:   w_clr[7:0]    = csr_di;
                5'h09:   w_clr[15:8]   = csr_di;
                5'h0A:   mode_d[7:0]   = csr_di;
                5'h0B:   mode_d[15:8]  = csr_di;
                5'h0C:   mode_d[23:16] = csr_di;
                5'h0D:   mode_d[31:24] = csr_di;
                5'h0E:   dbe_d[7:0]    = csr_di;
                5'h0F:   dbe_d[15:8]   = csr_di;
                5'h10:   dbp_d         = csr_di;
                default: ;
            endcase
        end
        oe_d  = oe_d & c_PIN_MASK;
        out_d = out_d & c_PIN_MASK;
        ie_d  = ie_d & c_PIN_MASK;
        dbe_d = dbe_d & c_PIN_MASK;
        for (int n = 0; n < 16; n++) begin
            if (!c_PIN_MASK[n]) mode_d[2*n +: 2] = 2'b00;
        end
        // Setting beats clearing so a coincident event is never lost.
        ip_d = ((ip_q & ~w_clr) | w_event) & c_PIN_MASK;

        if (csr_we && (w_off == 5'h10)) presc_d = csr_di;
        else if (w_tick)                 presc_d = dbp_q;
        else                             presc_d = presc_q - 8'd1;
    end

    always_comb begin
        filt_d  = filt_q;
        dbcnt_d = dbcnt_q;
        for (int n = 0; n < 16; n++) begin
            if (!dbe_q[n]) begin
                filt_d[n]  = sync2_q[n];
                dbcnt_d[n] = 2'd0;
            end else if (sync2_q[n] == filt_q[n]) begin
                dbcnt_d[n] = 2'd0;
            end else if (w_tick) begin
                if (dbcnt_q[n] == 2'd3) begin
                    filt_d[n]  = sync2_q[n];
                    dbcnt_d[n] = 2'd0;
                end else begin
                    dbcnt_d[n] = dbcnt_q[n] + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            5'h00:   w_rdata = oe_q[7:0];
            5'h01:   w_rdata = oe_q[15:8];
            5'h02:   w_rdata = out_q[7:0];
            5'h03:   w_rdata = out_q[15:8];
            5'h04:   w_rdata = filt_q[7:0];
            5'h05:   w_rdata = filt_q[15:8];
            5'h06:   w_rdata = ie_q[7:0];
            5'h07:   w_rdata = ie_q[15:8];
            5'h08:   w_rdata = ip_q[7:0];
            5'h09:   w_rdata = ip_q[15:8];
            5'h0A:   w_rdata = mode_q[7:0];
            5'h0B:   w_rdata = mode_q[15:8];
            5'h0C:   w_rdata = mode_q[23:16];
            5'h0D:   w_rdata = mode_q[31:24];
            5'h0E:   w_rdata = dbe_q[7:0];
            5'h0F:   w_rdata = dbe_q[15:8];
            5'h10:   w_rdata = dbp_q;
            default: w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_q     <= '0;
            out_q    <= '0;
            ie_q     <= '0;
            ip_q     <= '0;
            mode_q   <= '0;
            dbe_q    <= '0;
            dbp_q    <= '0;
            presc_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            dbcnt_q  <= '0;
            csr_do_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            oe_q     <= oe_d;
            out_q    <= out_d;
            ie_q     <= ie_d;
            ip_q     <= ip_d;
            mode_q   <= mode_d;
            dbe_q    <= dbe_d;
            dbp_q    <= dbp_d;
            presc_q  <= presc_d;
            sync1_q  <= w_in;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            prev_q   <= filt_q;
            dbcnt_q  <= dbcnt_d;
            csr_do_q <= w_rdata;
            irq_q    <= |(ip_q & ie_q);
        end
    end

    assign csr_do = csr_do_q;
    assign irq    = irq_q;
    assign out    = out_q[NUM_GPIOS-1:0];
    assign oe     = oe_q[NUM_GPIOS-1:0];

endmodule

`default_nettype wire

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL: parameter BASE_ADDR, default 5'h00, first CSR byte address of the block.
REQ-002 SHALL: parameter NUM_GPIOS, default 16, pin count, legal range 1..16.
REQ-003 SHALL: clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL: csr_a  input  5  CSR byte address.
REQ-006 SHALL: csr_di  input  8  CSR write data.
REQ-007 SHALL: csr_we  input  1  CSR write strobe, single-cycle.
REQ-008 SHALL: csr_do  output  8  registered CSR read data.
REQ-009 SHALL: in  input  NUM_GPIOS  asynchronous pin inputs.
REQ-010 SHALL: out  output  NUM_GPIOS  pin output values.
REQ-011 SHALL: oe  output  NUM_GPIOS  pin output enables, 1 = drive.
REQ-012 SHALL: irq  output  1  registered level interrupt request.

Function
REQ-013 SHALL: register map, offsets from BASE_ADDR, lo byte = pins 7:0, hi byte = pins 15:8:
 - 0x0/0x1 OE (rw)
 - 0x2/0x3 OUT (rw)
 - 0x4/0x5 IN (ro, filtered value)
 - 0x6/0x7 IE (rw)
 - 0x8/0x9 IP (read; write-1-to-clear)
 - 0xA..0xD MODE (rw, 2 bits per pin, pin n at byte 0xA+n/4, bits 2*(n%4)+1:2*(n%4))
 - 0xE/0xF DBE, debounce enable (rw)
 - 0x10 DBP, debounce prescaler (rw, 8 bit)
REQ-014 SHALL: read latency 1 cycle; csr_do = addressed register one cycle after csr_a is presented, independent of csr_we.
REQ-015 SHALL: csr_do = 0 for unmapped offsets; bits for pins >= NUM_GPIOS read 0 and ignore writes.
REQ-016 SHALL: csr writes take effect on the clock edge where csr_we = 1; a read of the same address on the next cycle returns the new value.
REQ-017 SHALL: in passes through a 2-flop synchroniser (s); no other logic precedes it.
REQ-018 SHALL: prescaler: 8-bit down-counter; reloads with DBP and pulses tick for 1 cycle when it reaches 0; DBP = 0 gives tick every cycle; a DBP write reloads the counter.
REQ-019 SHALL: per pin with DBE = 1: 2-bit counter cleared whenever s == filt; on a tick while s != filt it increments; on the tick where it equals 3, filt <= s and counter clears (4 stable ticks to accept).
REQ-020 SHALL: per pin with DBE = 0: filt <= s every cycle, counter held at 0.
REQ-021 SHALL: prev = filt delayed one cycle; event per pin by MODE: 00 both edges (filt ^ prev), 01 rising, 10 falling, 11 level-low (filt == 0, asserted every cycle).
REQ-022 SHALL: IP bit set on event regardless of IE; IP bits clear only via write-1-to-clear.
REQ-023 SHALL: event and a clear of the same IP bit in the same cycle: event wins, bit stays 1.
REQ-024 SHALL: level-low pin keeps re-setting IP while filt == 0; a clear takes effect only once filt == 1.
REQ-025 SHALL: irq <= |(IP & IE) each cycle; asserts 1 cycle after the IP/IE state that causes it; deasserts 1 cycle after the last qualifying bit clears or its IE is cleared.
REQ-026 SHALL: MODE change produces no spurious edge event; prev continues tracking filt.
REQ-027 SHALL: latency from in change to IP set, DBE = 0, edge mode = 4 cycles (2 sync, 1 filt, 1 IP).

Reset
REQ-028 SHALL: on rst: OE, OUT, IE, IP, MODE, DBE, DBP = 0; sync flops, filt, prev, debounce counters, prescaler = 0; csr_do = 0; irq = 0.
REQ-029 SHALL: rst mid-debounce discards partial counts; no event is generated on the first cycles after reset release unless filt changes from 0.
REQ-030 SHALL: rst dominates csr_we in the same cycle.

Verification
REQ-031 SHALL: write 0xA5 to 0x0 and 0x3C to 0x3, then read 0x0, 0x3 -> csr_do = 0xA5, 0x3C one cycle after each address; oe[7:0] = 0xA5, out[15:8] = 0x3C.
REQ-032 SHALL: NUM_GPIOS = 16, MODE pin 0 = 01, IE[0] = 1, in[0] 0->1 -> IP[0] = 1 four cycles later, irq = 1 the cycle after; in[0] 1->0 -> no new event.
REQ-033 SHALL: DBE[1] = 1, DBP = 2, 1-cycle glitch on in[1] -> IN and IP unchanged; stable high for 12+ cycles -> IN[1] = 1 after 4 ticks.
REQ-034 SHALL: MODE pin 2 = 11, in[2] held 0, write 0x04 to IP lo -> IP[2] still reads 1; set in[2] = 1, write 0x04 -> IP[2] = 0, irq = 0 next cycle.
REQ-035 SHALL: edge on pin 3 in same cycle as a clear of IP[3] -> IP[3] reads 1.
REQ-036 SHALL: NUM_GPIOS = 5, write 0xFF to 0x2 and 0x3 -> reads 0x1F and 0x00; read offset 0x11 -> 0x00.
